// File: rtl/cpu_mem_bus_master_pkg.sv
// Shared types and constants for the CPU-side memory bus master.
package cpu_mem_bus_master_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

  typedef enum logic [1:0] {
    mbm_idle,
    mbm_hold,
    mbm_capture,
    mbm_resp
  } cpu_mem_bus_master_state;

endpackage

// File: rtl/cpu_mem_bus_master.sv
// Single-outstanding load/store initiator for the alternate-edge byte memory.
// Memory inputs are held HOLD_CYCLES edges so one service edge always lands inside.
module cpu_mem_bus_master
  import cpu_mem_bus_master_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_sz,
  input  logic              req_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_write_data_out,
  output logic              mem_data_acc_sz_out,
  output logic              mem_write_data_we_out,
  input  logic [DATA_W-1:0] mem_read_data_in
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  cpu_mem_bus_master_state r_state, w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we, r_sz;
  logic                    w_hold_done;
  logic [DATA_W-1:0]       w_wdata, w_rdata;

  assign req_ready   = (r_state == mbm_idle);
  assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYCLES - 1));

  // Byte stores drive only the low lane; upper lane is zeroed.
  assign w_wdata = (req_sz == cpu_data_acc_sz_8) ? DATA_W'(req_wdata[7:0]) : req_wdata;
  assign w_rdata = r_we ? '0 :
                   (r_sz == cpu_data_acc_sz_8) ? DATA_W'(mem_read_data_in[7:0]) : mem_read_data_in;

  always_comb begin
    w_next = r_state;
    case (r_state)
      mbm_idle:    if (req_valid)   w_next = mbm_hold;
      mbm_hold:    if (w_hold_done) w_next = mbm_capture;
      mbm_capture:                  w_next = mbm_resp;
      mbm_resp:    if (resp_ready)  w_next = mbm_idle;
      default:                      w_next = mbm_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= mbm_idle;
      r_cnt                 <= '0;
      r_we                  <= 1'b0;
      r_sz                  <= 1'b0;
      resp_valid            <= 1'b0;
      resp_rdata            <= '0;
      mem_addr_out          <= '0;
      mem_write_data_out    <= '0;
      mem_data_acc_sz_out   <= 1'b0;
      mem_write_data_we_out <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        mbm_idle: begin
          if (req_valid) begin
            mem_addr_out          <= req_addr;
            mem_write_data_out    <= w_wdata;
            mem_data_acc_sz_out   <= req_sz;
            mem_write_data_we_out <= req_we;
            r_we                  <= req_we;
            r_sz                  <= req_sz;
            r_cnt                 <= '0;
          end
        end
        mbm_hold: begin
          r_cnt <= r_cnt + 1'b1;
          // Address/size stay put; a re-read during capture returns the same data.
          if (w_hold_done) mem_write_data_we_out <= 1'b0;
        end
        mbm_capture: begin
          resp_valid <= 1'b1;
          resp_rdata <= w_rdata;
        end
        mbm_resp: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bus_master.sv
// Directed bench: alternate-edge memory model, transaction-level reference, per-cycle compare.
module tb_cpu_mem_bus_master;
  import cpu_mem_bus_master_pkg::*;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_sz, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr_out, mem_write_data_out, mem_read_data_in;
  logic        mem_data_acc_sz_out, mem_write_data_we_out;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  cpu_mem_bus_master #(.HOLD_CYCLES(H), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sz(req_sz), .req_we(req_we),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_addr_out(mem_addr_out), .mem_write_data_out(mem_write_data_out),
    .mem_data_acc_sz_out(mem_data_acc_sz_out), .mem_write_data_we_out(mem_write_data_we_out),
    .mem_read_data_in(mem_read_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: services its inputs on every other edge, little-endian, 16-bit read port.
  logic [7:0] mem [0:65535];
  logic       phase = 1'b0;
  bit         mem_init = 1'b0;
  int         wcount = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else begin
      phase <= ~phase;
      if (phase) begin
        mem_read_data_in <= {mem[mem_addr_out + 16'd1], mem[mem_addr_out]};
        if (mem_write_data_we_out) begin
          mem[mem_addr_out] <= mem_write_data_out[7:0];
          if (mem_data_acc_sz_out) mem[mem_addr_out + 16'd1] <= mem_write_data_out[15:8];
          wcount <= wcount + 1;
        end
      end
    end
  end

  // Reference: what the core should observe, tracked per transaction by edge count.
  logic [7:0]  refm [0:65535];
  bit          ref_init = 1'b0;
  int          cyc = 0;
  bit          busy = 1'b0;
  int          acc = 0;
  logic        e_we, e_sz;
  logic [15:0] e_addr, e_wdata, e_data;
  bit          resync = 1'b0;
  logic [15:0] rs_addr;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ref_init) begin
      for (int i = 0; i < 65536; i++) refm[i] <= pat(i);
      ref_init <= 1'b1;
    end
    if (reset) begin
      if (busy && e_we) begin resync <= 1'b1; rs_addr <= e_addr; end
      busy <= 1'b0; e_we <= 1'b0; e_sz <= 1'b0; e_addr <= '0; e_wdata <= '0;
    end else begin
      if (resync) begin
        // Aborted store may or may not have landed; adopt what memory holds.
        refm[rs_addr]         <= mem[rs_addr];
        refm[rs_addr + 16'd1] <= mem[rs_addr + 16'd1];
        resync <= 1'b0;
      end
      if (!busy && req_valid) begin
        busy    <= 1'b1;
        acc     <= cyc + 1;
        e_we    <= req_we;
        e_sz    <= req_sz;
        e_addr  <= req_addr;
        e_wdata <= req_sz ? req_wdata : {8'h00, req_wdata[7:0]};
        if (req_we) begin
          e_data <= '0;
          refm[req_addr] <= req_wdata[7:0];
          if (req_sz) refm[req_addr + 16'd1] <= req_wdata[15:8];
        end else begin
          e_data <= req_sz ? {refm[req_addr + 16'd1], refm[req_addr]} : {8'h00, refm[req_addr]};
        end
      end else if (busy && (cyc + 1 >= acc + H + 2) && resp_ready) begin
        busy <= 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("req_ready", req_ready, !busy);
        chk("resp_valid", resp_valid, busy && (cyc >= acc + H + 1));
        chk("mem_we", mem_write_data_we_out, busy && e_we && (cyc < acc + H));
        chk("mem_addr", mem_addr_out, e_addr);
        chk("mem_wdata", mem_write_data_out, e_wdata);
        chk("mem_sz", mem_data_acc_sz_out, e_sz);
        if (busy && (cyc >= acc + H + 1)) chk("resp_rdata", resp_rdata, e_data);
      end
    end
  end

  task automatic do_req(input logic we, input logic sz, input logic [15:0] a, input logic [15:0] wd,
                        input int bp, input logic [15:0] exp_rd, input string nm,
                        output int lat, output int wr);
    int t0, g, w0;
    w0 = wcount;
    req_valid = 1'b1; req_we = we; req_sz = sz; req_addr = a; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    chk({nm, "_accept"}, req_ready, 1);
    @(posedge clk); #1;
    t0 = cyc; req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 20) begin @(posedge clk); #1; g++; end
    lat = cyc - t0;
    chk({nm, "_rdata"}, resp_rdata, exp_rd);
    for (int i = 0; i < bp; i++) begin
      chk({nm, "_bp_valid"}, resp_valid, 1);
      chk({nm, "_bp_rdata"}, resp_rdata, exp_rd);
      chk({nm, "_bp_req_ready"}, req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, "_hs_valid"}, resp_valid, 0);
    chk({nm, "_hs_req_ready"}, req_ready, 1);
    wr = wcount - w0;
  endtask

  initial begin
    int lat, wr, g;
    int tr [3];
    logic [15:0] rv [3];
    logic [15:0] exp300;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_sz = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr_out, 0);
    chk("rst_mem_we", mem_write_data_we_out, 0);
    chk("rst_mem_wdata", mem_write_data_out, 0);
    reset = 1'b0;
    chk_on = 1'b1;

    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) begin @(posedge clk); #1; end  // shift to the opposite memory phase
      do_req(1'b1, cpu_data_acc_sz_16, 16'h0100, 16'hBEEF, 0, 16'h0000, "st16", lat, wr);
      chk("st16_lat", lat, H + 1);
      chk("st16_writes", wr, 1);
      do_req(1'b0, cpu_data_acc_sz_16, 16'h0100, 16'h0000, 0, 16'hBEEF, "ld16", lat, wr);
      chk("ld16_lat", lat, H + 1);
    end

    do_req(1'b1, cpu_data_acc_sz_8, 16'h0200, 16'h12A5, 0, 16'h0000, "st8", lat, wr);
    chk("st8_writes", wr, 1);
    do_req(1'b0, cpu_data_acc_sz_8, 16'h0200, 16'hFFFF, 0, 16'h00A5, "ld8", lat, wr);
    do_req(1'b0, cpu_data_acc_sz_8, 16'h0201, 16'h0000, 0, 16'h000A, "ld8_hi", lat, wr);

    do_req(1'b0, cpu_data_acc_sz_16, 16'h0010, 16'h0000, 5, 16'h7A73, "bp", lat, wr);
    do_req(1'b0, cpu_data_acc_sz_16, 16'hFFFF, 16'h0000, 0, 16'h03FC, "wrap", lat, wr);

    // Reset while a store is holding.
    req_valid = 1'b1; req_we = 1'b1; req_sz = cpu_data_acc_sz_16;
    req_addr = 16'h0300; req_wdata = 16'h5A5A;
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold_we", mem_write_data_we_out, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rmid_req_ready", req_ready, 1);
    chk("rmid_we", mem_write_data_we_out, 0);
    chk("rmid_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    exp300 = {mem[16'h0301], mem[16'h0300]};
    do_req(1'b0, cpu_data_acc_sz_16, 16'h0300, 16'h0000, 0, exp300, "ld300", lat, wr);
    chk("ld300_lat", lat, H + 1);

    // Back-to-back loads with req_valid held high.
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_sz = cpu_data_acc_sz_16;
    for (int i = 0; i < 3; i++) begin
      req_addr = 16'(2 * i);
      g = 0;
      while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
      g = 0;
      while (req_ready && g < 20) begin @(posedge clk); #1; g++; end
      chk("b2b_accept", req_ready, 0);
      if (i == 2) req_valid = 1'b0;
      g = 0;
      while (!resp_valid && g < 20) begin @(posedge clk); #1; g++; end
      tr[i] = cyc;
      rv[i] = resp_rdata;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("b2b_d0", rv[0], 16'h0A03);
    chk("b2b_d1", rv[1], 16'h1811);
    chk("b2b_d2", rv[2], 16'h261F);
    chk("b2b_gap01", tr[1] - tr[0], H + 3);
    chk("b2b_gap12", tr[2] - tr[1], H + 3);
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    total++; bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
